// File: rtl/param_multdiv.sv
// param_multdiv: sequential signed multiplier / divider, one bit per clock.
//
// A start strobe latches both operands and the mode. The unit then runs
// WIDTH iteration cycles on operand magnitudes (shift-add for multiply,
// restoring division for divide). A single FIX cycle applies the sign and
// computes the exception, and the unit presents the result with a one-cycle
// ready pulse.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous active-high reset, returns to IDLE
//   data_operandA   multiplicand / dividend (signed, WIDTH bits)
//   data_operandB   multiplier / divisor (signed, WIDTH bits)
//   ctrl_MULT       start-multiply strobe
//   ctrl_DIV        start-divide strobe
//   data_result     product low bits or quotient (held until the next FIX)
//   data_exception  overflow / divide-by-zero flag, valid with data_result
//   data_resultRDY  one-cycle result-valid pulse
//   busy            high during RUN and FIX
module param_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t             state_q;
  logic [CW-1:0]      count_q;
  logic               div_q;     // latched mode: 1 = divide
  logic               neg_q;     // operand signs differ
  logic               bzero_q;   // divisor was zero
  logic [2*WIDTH-1:0] acc_q;     // product magnitude accumulator
  logic [2*WIDTH-1:0] mcand_q;   // multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0]   quo_q;     // mult: multiplier shifting right; div: dividend in, quotient out
  logic [WIDTH-1:0]   opb_q;     // divisor magnitude
  logic [WIDTH-1:0]   rem_q;     // partial remainder (always below the divisor)
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;
  logic               rdy_q;
  logic               busy_q;

  logic               start_s;
  logic [WIDTH:0]     shifted_d;
  logic               ge_d;
  logic [WIDTH-1:0]   rem_sub_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   quo_signed_d;
  logic [WIDTH-1:0]   result_d;
  logic               exc_d;

  // Unsigned magnitude. An unsigned WIDTH-bit value holds 2^(WIDTH-1), so the
  // most negative operand needs no special case here.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  assign start_s = ctrl_MULT ^ ctrl_DIV;

  // Restoring-division step and FIX-cycle sign/exception evaluation.
  always_comb begin
    shifted_d    = {rem_q, quo_q[WIDTH-1]};
    ge_d         = (shifted_d >= {1'b0, opb_q});
    // The true difference is below the divisor, so the low WIDTH bits are exact.
    rem_sub_d    = shifted_d[WIDTH-1:0] - opb_q;
    prod_d       = neg_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
    quo_signed_d = neg_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
    result_d     = {WIDTH{1'b0}};
    exc_d        = 1'b0;
    if (!div_q) begin
      result_d = prod_d[WIDTH-1:0];
      // Representable only if the top WIDTH+1 bits are pure sign extension.
      exc_d    = ~((&prod_d[2*WIDTH-1:WIDTH-1]) | ~(|prod_d[2*WIDTH-1:WIDTH-1]));
    end else if (bzero_q) begin
      result_d = {WIDTH{1'b0}};
      exc_d    = 1'b1;
    end else begin
      result_d = quo_signed_d;
      // Only a positive quotient of 2^(WIDTH-1) (MIN / -1) overflows.
      exc_d    = quo_q[WIDTH-1] & ~neg_q;
    end
  end

  // Control FSM, datapath iteration and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= {CW{1'b0}};
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          rdy_q <= 1'b0;
          if (start_s) begin
            div_q   <= ctrl_DIV;
            neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            bzero_q <= (data_operandB == {WIDTH{1'b0}});
            acc_q   <= {(2*WIDTH){1'b0}};
            mcand_q <= {{WIDTH{1'b0}}, mag(data_operandA)};
            quo_q   <= ctrl_DIV ? mag(data_operandA) : mag(data_operandB);
            opb_q   <= mag(data_operandB);
            rem_q   <= {WIDTH{1'b0}};
            count_q <= {CW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          count_q <= count_q + CNT_ONE;
          if (!div_q) begin
            if (quo_q[0]) begin
              acc_q <= acc_q + mcand_q;
            end else begin
              acc_q <= acc_q;
            end
            mcand_q <= {mcand_q[2*WIDTH-2:0], 1'b0};
            quo_q   <= {1'b0, quo_q[WIDTH-1:1]};
          end else begin
            rem_q <= ge_d ? rem_sub_d : shifted_d[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], ge_d};
          end
          if (count_q == CNT_LAST) begin
            state_q <= FIX;
          end else begin
            state_q <= RUN;
          end
        end
        FIX: begin
          result_q <= result_d;
          exc_q    <= exc_d;
          rdy_q    <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= DONE;
        end
        default: begin
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_param_multdiv.sv
module tb_param_multdiv;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a4, b4, res4;
  logic        m4, d4, exc4, rdy4, busy4;
  logic [31:0] a32, b32, res32;
  logic        m32, d32, exc32, rdy32, busy32;

  always #5 clk = ~clk;

  param_multdiv #(.WIDTH(4)) dut4 (
    .clock(clk), .reset(rst), .data_operandA(a4), .data_operandB(b4),
    .ctrl_MULT(m4), .ctrl_DIV(d4), .data_result(res4),
    .data_exception(exc4), .data_resultRDY(rdy4), .busy(busy4)
  );

  param_multdiv #(.WIDTH(32)) dut32 (
    .clock(clk), .reset(rst), .data_operandA(a32), .data_operandB(b32),
    .ctrl_MULT(m32), .ctrl_DIV(d32), .data_result(res32),
    .data_exception(exc32), .data_resultRDY(rdy32), .busy(busy32)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     w;
    bit     dv;
    longint a;
    longint b;
    longint res;
    bit     exc;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int w, input longint v);
    logic [63:0] u;
    u = v;
    return (w == 4) ? (u & 64'hF) : (u & 64'hFFFF_FFFF);
  endfunction

  // Reference: exact signed arithmetic, then range test and truncation.
  task automatic model(input int w, input bit dv, input longint a, input longint b,
                       output logic [63:0] res, output bit exc);
    longint lo, hi, r;
    lo = -(64'sd1 <<< (w - 1));
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (dv && b == 0) begin
      res = 64'd0;
      exc = 1'b1;
    end else begin
      r   = dv ? (a / b) : (a * b);
      exc = (r < lo) || (r > hi);
      res = mask(w, r);
    end
  endtask

  task automatic drive(input int w, input bit mu, input bit dv, input longint a, input longint b);
    if (w == 4) begin
      a4 = a[3:0]; b4 = b[3:0]; m4 = mu; d4 = dv;
    end else begin
      a32 = a[31:0]; b32 = b[31:0]; m32 = mu; d32 = dv;
    end
  endtask

  function automatic logic [63:0] get_res(input int w);
    return (w == 4) ? {60'd0, res4} : {32'd0, res32};
  endfunction
  function automatic logic get_exc(input int w);
    return (w == 4) ? exc4 : exc32;
  endfunction
  function automatic logic get_rdy(input int w);
    return (w == 4) ? rdy4 : rdy32;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 4) ? busy4 : busy32;
  endfunction

  // Counts edges from now until ready is seen (bounded); bc counts busy samples before it.
  task automatic wait_rdy(input int w, output int lat, output int bc);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    bc   = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      lat++;
      if (get_rdy(w)) begin
        seen = 1'b1;
        break;
      end
      if (get_busy(w)) bc++;
    end
    if (!seen) lat = -1;
  endtask

  // Called with a start already driven: takes edge 0, scrambles operands, waits for ready.
  task automatic wait_done(input int w, output int lat, output int bc);
    int l2, b2;
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0, longint'($urandom), longint'($urandom));
    bc = get_busy(w) ? 1 : 0;
    wait_rdy(w, l2, b2);
    lat = l2;
    bc += b2;
  endtask

  task automatic op_check(input string name, input int w, input bit dv, input longint a,
                          input longint b, input logic [63:0] exp_res, input bit exp_exc);
    int lat, bc;
    @(negedge clk);
    drive(w, !dv, dv, a, b);
    wait_done(w, lat, bc);
    chk({name, "_res"}, get_res(w), exp_res);
    chk({name, "_exc"}, {63'd0, get_exc(w)}, {63'd0, exp_exc});
    chk({name, "_lat"}, lat, w + 1);
    chk({name, "_busy"}, bc, w + 1);
  endtask

  initial begin
    logic [63:0] er;
    bit          ee;
    int          lat, bc, ra, rb;
    bit          seen;

    rst = 1'b1;
    drive(4, 1'b0, 1'b0, 0, 0);
    drive(32, 1'b0, 1'b0, 0, 0);
    #1;
    chk("rst_res4", {60'd0, res4}, 64'd0);
    chk("rst_flags4", {60'd0, exc4, rdy4, busy4, 1'b0}, 64'd0);
    chk("rst_res32", {32'd0, res32}, 64'd0);
    chk("rst_flags32", {60'd0, exc32, rdy32, busy32, 1'b0}, 64'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Directed table: expectations written out by hand.
    tbl[0]  = '{32, 1'b0, 64'sd2147483647, 64'sd2, 64'hFFFF_FFFE, 1'b1};
    tbl[1]  = '{32, 1'b0, -64'sd6, 64'sd7, 64'hFFFF_FFD6, 1'b0};
    tbl[2]  = '{32, 1'b1, 64'sd100, -64'sd7, 64'hFFFF_FFF2, 1'b0};
    tbl[3]  = '{32, 1'b1, -64'sd2147483648, -64'sd1, 64'h8000_0000, 1'b1};
    tbl[4]  = '{32, 1'b1, 64'sd5, 64'sd0, 64'h0, 1'b1};
    tbl[5]  = '{4, 1'b0, 64'sd3, 64'sd3, 64'h9, 1'b1};
    tbl[6]  = '{4, 1'b0, -64'sd8, 64'sd1, 64'h8, 1'b0};
    tbl[7]  = '{4, 1'b1, -64'sd8, -64'sd1, 64'h8, 1'b1};
    tbl[8]  = '{4, 1'b1, 64'sd7, -64'sd2, 64'hD, 1'b0};
    tbl[9]  = '{4, 1'b1, -64'sd7, 64'sd2, 64'hD, 1'b0};
    tbl[10] = '{4, 1'b1, 64'sd5, 64'sd0, 64'h0, 1'b1};
    tbl[11] = '{4, 1'b0, -64'sd8, -64'sd8, 64'h0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      op_check($sformatf("tbl%0d", i), tbl[i].w, tbl[i].dv, tbl[i].a, tbl[i].b,
               tbl[i].res, tbl[i].exc);
    end

    // Exhaustive WIDTH=4 multiply and divide.
    for (int dv = 0; dv < 2; dv++) begin
      for (int a = -8; a < 8; a++) begin
        for (int b = -8; b < 8; b++) begin
          model(4, dv[0], a, b, er, ee);
          op_check($sformatf("ex4_%s_%0d_%0d", dv ? "div" : "mul", a, b), 4, dv[0], a, b, er, ee);
        end
      end
    end

    // Random WIDTH=32 operations.
    for (int i = 0; i < 30; i++) begin
      bit dv;
      dv = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ((i % 3) == 0) ? ($urandom_range(0, 20) - 10) : $urandom;
      model(32, dv, ra, rb, er, ee);
      op_check($sformatf("rnd32_%0d", i), 32, dv, ra, rb, er, ee);
    end

    // Both strobes high: nothing starts.
    @(negedge clk);
    drive(4, 1'b1, 1'b1, 3, 3);
    @(posedge clk); #1;
    chk("both_busy", {63'd0, busy4}, 64'd0);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b0, 0, 0);
    chk("both_busy2", {63'd0, busy4}, 64'd0);
    chk("both_rdy", {63'd0, rdy4}, 64'd0);

    // Strobe mid-RUN ignored; start in the DONE cycle accepted.
    @(negedge clk);
    drive(4, 1'b1, 1'b0, 3, -2);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b0, 0, 0);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b1, 7, 1);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b0, 0, 0);
    wait_rdy(4, lat, bc);
    chk("mid_lat", lat + 2, 5);
    chk("mid_res", {60'd0, res4}, 64'hA);
    chk("mid_exc", {63'd0, exc4}, 64'd0);
    drive(4, 1'b0, 1'b1, 7, -2);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b0, 0, 0);
    chk("b2b_hold", {60'd0, res4}, 64'hA);
    chk("b2b_rdy_drop", {63'd0, rdy4}, 64'd0);
    chk("b2b_busy", {63'd0, busy4}, 64'd1);
    wait_rdy(4, lat, bc);
    chk("b2b_gap", lat + 1, 6);
    chk("b2b_res", {60'd0, res4}, 64'hD);
    chk("b2b_exc", {63'd0, exc4}, 64'd0);

    // Reset mid-RUN at count = WIDTH/2.
    op_check("pre_rst", 4, 1'b0, 3, 3, 64'h9, 1'b1);
    @(negedge clk);
    drive(4, 1'b1, 1'b0, 5, 5);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_res", {60'd0, res4}, 64'd0);
    chk("abort_flags", {61'd0, exc4, rdy4, busy4}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rdy4 || busy4) seen = 1'b1;
    end
    chk("abort_no_rdy", {63'd0, seen}, 64'd0);
    model(4, 1'b0, -7, 3, er, ee);
    op_check("post_rst", 4, 1'b0, -7, 3, er, ee);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
